// File: rtl/reg_dump_reader_pkg.sv
// Shared types and sizes for the register-file dump reader.
// Holds the dump FSM state encoding and the word/byte geometry helpers.
package reg_dump_reader_pkg;

  localparam int NUM_REGS       = 32;
  localparam int REG_ADDR_W     = 5;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_LATCH,
    S_SEND,
    S_DONE
  } state_t;

  // Byte k of a word, most significant byte first.
  function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] word,
                                                  input logic [1:0]        k);
    return word[WORD_W-1-BYTE_W*int'(k) -: BYTE_W];
  endfunction

endpackage

// File: rtl/reg_dump_reader_if.sv
// Byte-stream valid/ready channel carrying the dump output.
interface reg_dump_reader_if;
  import reg_dump_reader_pkg::*;

  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/reg_dump_reader_serializer.sv
// Turns one captured register word (plus optional address byte) into a
// back-to-back byte stream and reports when its last byte is accepted.
module reg_dump_serializer
  import reg_dump_reader_pkg::*;
#(
  parameter int SEND_ADDR = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WORD_W-1:0]     word_in,
  input  logic [REG_ADDR_W-1:0] addr_in,
  output logic                  last_accepted,
  reg_dump_reader_if.master     tx
);

  localparam int         NUM_BYTES = BYTES_PER_WORD + ((SEND_ADDR != 0) ? 1 : 0);
  localparam logic [2:0] LAST_IDX  = 3'(NUM_BYTES - 1);

  logic [WORD_W-1:0]     word_q, word_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]            byte_idx_q, byte_idx_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [BYTE_W-1:0]     tx_data_q, tx_data_d;
  logic                  transfer;

  function automatic logic [BYTE_W-1:0] byte_at(input logic [2:0]            pos,
                                                input logic [WORD_W-1:0]     w,
                                                input logic [REG_ADDR_W-1:0] a);
    logic [1:0] k;
    k = 2'((SEND_ADDR != 0) ? pos - 3'd1 : pos);
    if (SEND_ADDR != 0 && pos == 3'd0) return {{(BYTE_W-REG_ADDR_W){1'b0}}, a};
    return word_byte(w, k);
  endfunction

  always_comb begin
    word_d        = word_q;
    addr_d        = addr_q;
    byte_idx_d    = byte_idx_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    transfer      = tx_valid_q && tx.tx_ready;
    last_accepted = transfer && (byte_idx_q == LAST_IDX);
    if (load) begin
      word_d     = word_in;
      addr_d     = addr_in;
      byte_idx_d = 3'd0;
      tx_valid_d = 1'b1;
      tx_data_d  = byte_at(3'd0, word_in, addr_in);
    end else if (transfer) begin
      // Data only moves on an accepted byte, so it is frozen through stalls.
      if (byte_idx_q == LAST_IDX) begin
        tx_valid_d = 1'b0;
      end else begin
        byte_idx_d = byte_idx_q + 3'd1;
        tx_data_d  = byte_at(byte_idx_q + 3'd1, word_q, addr_q);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      word_q     <= '0;
      addr_q     <= '0;
      byte_idx_q <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      word_q     <= word_d;
      addr_q     <= addr_d;
      byte_idx_q <= byte_idx_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx.tx_valid = tx_valid_q;
  assign tx.tx_data  = tx_data_q;

endmodule

// File: rtl/reg_dump_reader.sv
// Walks a (possibly wrapping) range of register-file entries through the
// debug read port and streams each one out as bytes.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int SEND_ADDR = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [REG_ADDR_W-1:0] first_addr,
  input  logic [REG_ADDR_W-1:0] last_addr,
  output logic [REG_ADDR_W-1:0] debug_read_addr,
  output logic                  debug_strobe,
  input  logic [WORD_W-1:0]     debug_data,
  reg_dump_reader_if.master     tx,
  output logic                  busy,
  output logic                  done
);

  state_t                state_q, state_d;
  logic [REG_ADDR_W-1:0] index_q, index_d;
  logic [REG_ADDR_W-1:0] end_q, end_d;
  logic [REG_ADDR_W-1:0] debug_read_addr_q, debug_read_addr_d;
  logic                  debug_strobe_q, debug_strobe_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  last_accepted;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    end_d   = end_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          index_d = first_addr;
          end_d   = last_addr;
          state_d = S_REQ;
        end
      end
      S_REQ:   state_d = S_WAIT;
      S_WAIT:  state_d = S_LATCH;
      S_LATCH: state_d = S_SEND;
      S_SEND: begin
        if (last_accepted) begin
          if (index_q == end_q) begin
            state_d = S_DONE;
          end else begin
            index_d = (index_q == REG_ADDR_W'(NUM_REGS - 1)) ? '0 : index_q + 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they describe.
    debug_strobe_d    = (state_d == S_REQ);
    debug_read_addr_d = (state_d == S_REQ) ? index_d : debug_read_addr_q;
    busy_d            = (state_d == S_REQ) || (state_d == S_WAIT) ||
                        (state_d == S_LATCH) || (state_d == S_SEND);
    done_d            = (state_d == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= S_IDLE;
      index_q           <= '0;
      end_q             <= '0;
      debug_read_addr_q <= '0;
      debug_strobe_q    <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      index_q           <= index_d;
      end_q             <= end_d;
      debug_read_addr_q <= debug_read_addr_d;
      debug_strobe_q    <= debug_strobe_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
    end
  end

  reg_dump_serializer #(
    .SEND_ADDR (SEND_ADDR)
  ) u_serializer (
    .clock         (clock),
    .reset         (reset),
    .load          (state_q == S_LATCH),
    .word_in       (debug_data),
    .addr_in       (index_q),
    .last_accepted (last_accepted),
    .tx            (tx)
  );

  assign debug_read_addr = debug_read_addr_q;
  assign debug_strobe    = debug_strobe_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: one instance with address bytes, one
// without, each fed by a falling-edge-capture register file model.
module tb_reg_dump_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [4:0]  first_addr = '0;
  logic [4:0]  last_addr = '0;
  logic [4:0]  dra0, dra1;
  logic        ds0, ds1;
  logic [31:0] dd0, dd1;
  logic        busy0, busy1, done0, done1;
  logic        rand_mode = 1'b0;

  logic [31:0] regs0 [32];
  logic [31:0] regs1 [32];

  int checks = 0;
  int failures = 0;

  reg_dump_reader_if tx0 ();
  reg_dump_reader_if tx1 ();

  always #5 clock = ~clock;

  reg_dump_reader #(.SEND_ADDR(1)) u_dut0 (
    .clock(clock), .reset(reset), .start(start0),
    .first_addr(first_addr), .last_addr(last_addr),
    .debug_read_addr(dra0), .debug_strobe(ds0), .debug_data(dd0),
    .tx(tx0), .busy(busy0), .done(done0)
  );

  reg_dump_reader #(.SEND_ADDR(0)) u_dut1 (
    .clock(clock), .reset(reset), .start(start1),
    .first_addr(first_addr), .last_addr(last_addr),
    .debug_read_addr(dra1), .debug_strobe(ds1), .debug_data(dd1),
    .tx(tx1), .busy(busy1), .done(done1)
  );

  // Register file debug port captures on the falling edge of its strobe.
  always @(negedge ds0) dd0 = regs0[dra0];
  always @(negedge ds1) dd1 = regs1[dra1];

  always @(posedge clock) begin
    #1;
    tx0.tx_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int   done_cnt0 = 0, done_cnt1 = 0, strobe_cnt0 = 0, stall_err0 = 0, done_bad0 = 0;
  logic prev_stall0 = 1'b0, prev_xfer0 = 1'b0;
  logic [7:0] prev_data0 = '0;

  always @(negedge clock) begin
    if (tx0.tx_valid && tx0.tx_ready) q0.push_back(tx0.tx_data);
    if (prev_stall0 && (!tx0.tx_valid || tx0.tx_data !== prev_data0)) stall_err0++;
    prev_stall0 = tx0.tx_valid && !tx0.tx_ready;
    prev_data0  = tx0.tx_data;
    if (ds0) strobe_cnt0++;
    if (done0) begin
      done_cnt0++;
      if (!prev_xfer0 || busy0) done_bad0++;
    end
    prev_xfer0 = tx0.tx_valid && tx0.tx_ready;
    if (tx1.tx_valid && tx1.tx_ready) q1.push_back(tx1.tx_data);
    if (done1) done_cnt1++;
  end

  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input int first, input int last, input bit sa);
    int r;
    logic [31:0] w;
    exp_q.delete();
    r = first;
    for (int n = 0; n < 32; n++) begin
      w = sa ? regs0[r] : regs1[r];
      if (sa) exp_q.push_back(8'(r));
      exp_q.push_back(w[31:24]);
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
      if (r == last) break;
      r = (r + 1) % 32;
    end
  endtask

  task automatic check_stream(input bit which, input int base, input string tag);
    int n, f;
    logic [7:0] b;
    n = which ? q1.size() - base : q0.size() - base;
    chk({tag, "_count"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      b = which ? q1[base + i] : q0[base + i];
      f = failures;
      chk($sformatf("%s_byte%0d", tag, i), 32'(b), 32'(exp_q[i]));
      if (failures != f) break;
    end
  endtask

  task automatic start_dump(input bit which, input logic [4:0] f, input logic [4:0] l);
    @(posedge clock);
    #1;
    first_addr = f;
    last_addr  = l;
    if (which) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clock);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Counts cycles after the start edge until done is seen; optionally pulses
  // start0 for one edge at cycle pulse_n.
  task automatic wait_done(input bit which, input int budget, input int pulse_n, output int n);
    int base;
    base = which ? done_cnt1 : done_cnt0;
    n = 0;
    while (((which ? done_cnt1 : done_cnt0) == base) && n < budget) begin
      @(negedge clock);
      #1;
      n++;
      if (pulse_n != 0 && n == pulse_n) start0 = 1'b1;
      if (pulse_n != 0 && n == pulse_n + 1) start0 = 1'b0;
    end
    chk("done_seen", 32'((which ? done_cnt1 : done_cnt0) != base), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, s, d, n, sz;
    for (int i = 0; i < 32; i++) begin
      regs0[i] = 32'h100 + 32'(i);
      regs1[i] = 32'h100 + 32'(i);
    end
    regs1[5] = 32'hDEADBEEF;
    tx1.tx_ready = 1'b1;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    chk("rst_tx_valid", 32'(tx0.tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx0.tx_data), 32'd0);
    chk("rst_strobe", 32'(ds0), 32'd0);
    chk("rst_raddr", 32'(dra0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Single register 3..3: 03 00 00 01 03, 3+5 cycles then DONE
    b = q0.size(); s = strobe_cnt0;
    start_dump(0, 5'd3, 5'd3);
    chk("s1_busy_req", 32'(busy0), 32'd1);
    chk("s1_strobe_req", 32'(ds0), 32'd1);
    chk("s1_raddr", 32'(dra0), 32'd3);
    wait_done(0, 50, 0, n);
    chk("s1_cycles", 32'(n), 32'd9);
    chk("s1_done", 32'(done0), 32'd1);
    chk("s1_busy_done", 32'(busy0), 32'd0);
    build_exp(3, 3, 1'b1);
    check_stream(0, b, "s1");
    chk("s1_b0", 32'(q0[b]), 32'h03);
    chk("s1_b4", 32'(q0[b + 4]), 32'h03);
    chk("s1_strobes", 32'(strobe_cnt0 - s), 32'd1);
    chk("s1_done_timing", 32'(done_bad0), 32'd0);
    @(posedge clock); #1;
    chk("s1_done_pulse", 32'(done0), 32'd0);

    // Wrapping range 30..1
    b = q0.size(); s = strobe_cnt0;
    start_dump(0, 5'd30, 5'd1);
    wait_done(0, 100, 0, n);
    chk("s2_cycles", 32'(n), 32'd33);
    build_exp(30, 1, 1'b1);
    check_stream(0, b, "s2");
    chk("s2_strobes", 32'(strobe_cnt0 - s), 32'd4);

    // Random backpressure on the same range
    rand_mode = 1'b1;
    b = q0.size();
    start_dump(0, 5'd30, 5'd1);
    wait_done(0, 2000, 0, n);
    check_stream(0, b, "s3");
    chk("s3_stall_stable", 32'(stall_err0), 32'd0);
    rand_mode = 1'b0;
    @(posedge clock); #1;

    // Reset during the second data byte of a 0..31 dump
    b = q0.size(); d = done_cnt0;
    start_dump(0, 5'd0, 5'd31);
    n = 0;
    while (q0.size() < b + 3 && n < 50) begin
      @(negedge clock); #1;
      n++;
    end
    chk("s4_reached", 32'(q0.size() - b), 32'd3);
    reset = 1'b1;
    @(negedge clock); #1;
    chk("s4_tx_valid", 32'(tx0.tx_valid), 32'd0);
    chk("s4_busy", 32'(busy0), 32'd0);
    reset = 1'b0;
    sz = q0.size();
    repeat (20) @(negedge clock);
    #1;
    chk("s4_no_bytes", 32'(q0.size() - sz), 32'd0);
    chk("s4_no_done", 32'(done_cnt0 - d), 32'd0);
    b = q0.size();
    start_dump(0, 5'd3, 5'd3);
    wait_done(0, 50, 0, n);
    chk("s4_re_cycles", 32'(n), 32'd9);
    build_exp(3, 3, 1'b1);
    check_stream(0, b, "s4");

    // Start while busy and in the DONE cycle, both ignored
    b = q0.size(); s = strobe_cnt0; d = done_cnt0;
    start_dump(0, 5'd3, 5'd4);
    first_addr = 5'd10; last_addr = 5'd10;
    wait_done(0, 100, 5, n);
    chk("s5_cycles", 32'(n), 32'd17);
    first_addr = 5'd20; last_addr = 5'd20;
    start0 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0;
    chk("s5_idle_busy", 32'(busy0), 32'd0);
    repeat (20) @(negedge clock);
    #1;
    build_exp(3, 4, 1'b1);
    check_stream(0, b, "s5");
    chk("s5_done_count", 32'(done_cnt0 - d), 32'd1);
    chk("s5_strobes", 32'(strobe_cnt0 - s), 32'd2);
    chk("s5_busy_after", 32'(busy0), 32'd0);

    // Data-only variant, 0..31
    b = q1.size();
    start_dump(1, 5'd0, 5'd31);
    wait_done(1, 400, 0, n);
    chk("s6_cycles", 32'(n), 32'd225);
    build_exp(0, 31, 1'b0);
    check_stream(1, b, "s6");
    if (q1.size() >= b + 128) begin
      chk("s6_b20", 32'(q1[b + 20]), 32'hDE);
      chk("s6_b21", 32'(q1[b + 21]), 32'hAD);
      chk("s6_b22", 32'(q1[b + 22]), 32'hBE);
      chk("s6_b23", 32'(q1[b + 23]), 32'hEF);
      chk("s6_b127", 32'(q1[b + 127]), 32'h1F);
    end else begin
      chk("s6_len", 32'(q1.size() - b), 32'd128);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
